// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : UART receiver assembling W_OUT/BITS_PER_WORD serial words into
//               one parallel frame, with parity/framing/overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data,
    output logic             err_frame,
    output logic             err_parity,
    output logic             err_overrun
);

    localparam int c_NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int c_CW = ($clog2(CLOCKS_PER_PULSE) > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int c_BW = ($clog2(BITS_PER_WORD) > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int c_WW = ($clog2(c_NUM_WORDS) > 1) ? $clog2(c_NUM_WORDS) : 1;

    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL_LAST = c_CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(BITS_PER_WORD - 1);
    localparam logic [c_WW-1:0] c_WORD_LAST = c_WW'(c_NUM_WORDS - 1);
    localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic            c_ODD       = (PARITY == 2);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [SYNC_STAGES-1:0]   r_sync;
    logic [2:0]               r_state;
    logic [c_CW-1:0]          r_clk;
    logic [c_BW-1:0]          r_bit;
    logic                     r_stop;
    logic [c_WW-1:0]          r_words;
    logic [BITS_PER_WORD-1:0] r_word;
    logic [W_OUT-1:0]         r_frame;
    logic                     r_par;
    logic                     r_bad_par;
    logic                     r_bad_frame;

    logic                     w_rxs;
    logic                     w_tick;
    logic                     w_out_free;
    logic [BITS_PER_WORD-1:0] w_word_shift;
    logic [W_OUT-1:0]         w_frame_next;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_tick     = (r_clk == c_FULL_LAST);
    assign w_out_free = !m_valid || m_ready;

    if (BITS_PER_WORD > 1) begin : g_shift_wide
        assign w_word_shift = {w_rxs, r_word[BITS_PER_WORD-1:1]};
    end else begin : g_shift_single
        assign w_word_shift = w_rxs;
    end

    // Frame as it would look with the just-finished word dropped into its slot.
    always_comb begin
        w_frame_next = r_frame;
        w_frame_next[r_words*BITS_PER_WORD +: BITS_PER_WORD] = r_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync      <= '1;
            r_state     <= c_IDLE;
            r_clk       <= '0;
            r_bit       <= '0;
            r_stop      <= 1'b0;
            r_words     <= '0;
            r_word      <= '0;
            r_frame     <= '0;
            r_par       <= 1'b0;
            r_bad_par   <= 1'b0;
            r_bad_frame <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], rx};
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (!w_rxs) begin
                        r_state     <= c_START;
                        r_clk       <= '0;
                        r_bit       <= '0;
                        r_stop      <= 1'b0;
                        r_par       <= 1'b0;
                        r_bad_par   <= 1'b0;
                        r_bad_frame <= 1'b0;
                    end
                end

                c_START: begin
                    if (r_clk == c_HALF_LAST) begin
                        r_clk   <= '0;
                        r_state <= w_rxs ? c_IDLE : c_DATA;
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end

                c_DATA: begin
                    if (w_tick) begin
                        r_clk  <= '0;
                        r_word <= w_word_shift;
                        r_par  <= r_par ^ w_rxs;
                        if (r_bit == c_BIT_LAST) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? c_PARITY : c_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end

                c_PARITY: begin
                    if (w_tick) begin
                        r_clk   <= '0;
                        r_state <= c_STOP;
                        if ((r_par ^ w_rxs) != c_ODD) begin
                            r_bad_par <= 1'b1;
                        end
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end

                c_STOP: begin
                    if (w_tick) begin
                        r_clk <= '0;
                        if (r_stop == c_STOP_LAST) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            r_state <= c_IDLE;
                            if (r_bad_frame || !w_rxs) begin
                                err_frame <= 1'b1;
                                r_words   <= '0;
                            end else if (r_bad_par) begin
                                err_parity <= 1'b1;
                                r_words    <= '0;
                            end else if (r_words == c_WORD_LAST) begin
                                r_words <= '0;
                                if (w_out_free) begin
                                    m_data  <= w_frame_next;
                                    m_valid <= 1'b1;
                                end else begin
                                    err_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame <= w_frame_next;
                                r_words <= r_words + 1'b1;
                            end
                        end else begin
                            r_stop <= 1'b1;
                            if (!w_rxs) begin
                                r_bad_frame <= 1'b1;
                            end
                        end
                    end else begin
                        r_clk <= r_clk + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_framed
// Description : Directed bench for uart_rx_framed (8N1 instance and 8E1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framed;

    localparam int CPP = 4;

    logic        clk = 1'b0;
    logic        rstn, rx0, rx1, rdy0, rdy1;
    logic        v0, v1, fe0, pe0, oe0, fe1, pe1, oe1;
    logic [23:0] d0, d1;

    always #5 clk = ~clk;

    uart_rx_framed dut (
        .clk(clk), .rstn(rstn), .rx(rx0), .m_ready(rdy0), .m_valid(v0), .m_data(d0),
        .err_frame(fe0), .err_parity(pe0), .err_overrun(oe0)
    );

    uart_rx_framed #(.PARITY(1)) dut_p (
        .clk(clk), .rstn(rstn), .rx(rx1), .m_ready(rdy1), .m_valid(v1), .m_data(d1),
        .err_frame(fe1), .err_parity(pe1), .err_overrun(oe1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event counters updated at the falling edge, where outputs and inputs are settled.
    int acc0 = 0, acc1 = 0, fc0 = 0, pc0 = 0, oc0 = 0, fc1 = 0, pc1 = 0, oc1 = 0, multi = 0;
    logic [23:0] last0 = '0, last1 = '0;

    always @(negedge clk) begin
        if (v0 && rdy0) begin
            acc0  <= acc0 + 1;
            last0 <= d0;
        end
        if (v1 && rdy1) begin
            acc1  <= acc1 + 1;
            last1 <= d1;
        end
        fc0 <= fc0 + int'(fe0);
        pc0 <= pc0 + int'(pe0);
        oc0 <= oc0 + int'(oe0);
        fc1 <= fc1 + int'(fe1);
        pc1 <= pc1 + int'(pe1);
        oc1 <= oc1 + int'(oe1);
        if ((int'(fe0) + int'(pe0) + int'(oe0) > 1) || (int'(fe1) + int'(pe1) + int'(oe1) > 1))
            multi <= multi + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitdrv(input bit sel, input logic b);
        if (sel) rx1 = b;
        else     rx0 = b;
        cyc(CPP);
    endtask

    task automatic send_word(input bit sel, input logic [7:0] d, input bit use_par,
                             input logic pbit, input logic stopb);
        bitdrv(sel, 1'b0);
        for (int i = 0; i < 8; i++) bitdrv(sel, d[i]);
        if (use_par) bitdrv(sel, pbit);
        bitdrv(sel, stopb);
        if (!stopb) begin
            bitdrv(sel, 1'b1);
            bitdrv(sel, 1'b1);
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_word(1'b0, a, 1'b0, 1'b0, 1'b1);
        send_word(1'b0, b, 1'b0, 1'b0, 1'b1);
        send_word(1'b0, c, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_even(input logic [7:0] d);
        send_word(1'b1, d, 1'b1, ^d, 1'b1);
    endtask

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int a, e, f, p, o;

        tbl[0] = '{w0: 8'h00, w1: 8'hFF, w2: 8'h80, exp: 24'h80FF00};
        tbl[1] = '{w0: 8'hA5, w1: 8'h5A, w2: 8'h01, exp: 24'h015AA5};
        tbl[2] = '{w0: 8'hFF, w1: 8'hFF, w2: 8'hFF, exp: 24'hFFFFFF};
        tbl[3] = '{w0: 8'h81, w1: 8'h3C, w2: 8'hE7, exp: 24'hE73C81};

        rstn = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        cyc(3);
        chk("rst_valid", {31'd0, v0}, 32'd0);
        chk("rst_data", {8'd0, d0}, 32'd0);
        chk("rst_errs", {29'd0, fe0, pe0, oe0}, 32'd0);
        chk("rst_p_outs", {4'd0, d1, v1, fe1, pe1, oe1}, 32'd0);
        rstn = 1'b1;
        cyc(5);

        // Exact completion latency: valid appears one edge after the send ends.
        a = acc0;
        send3(8'h11, 8'h22, 8'h33);
        chk("lat_pre", {31'd0, v0}, 32'd0);
        cyc(1);
        chk("lat_valid", {31'd0, v0}, 32'd1);
        chk("lat_data", {8'd0, d0}, 32'h332211);
        cyc(1);
        chk("lat_drop", {31'd0, v0}, 32'd0);
        chk("lat_count", acc0 - a, 32'd1);

        // One-cycle low glitch must be rejected as a false start.
        a = acc0; e = fc0 + pc0 + oc0;
        rx0 = 1'b0;
        cyc(1);
        rx0 = 1'b1;
        cyc(20);
        chk("glitch_valid", acc0 - a, 32'd0);
        chk("glitch_errs", (fc0 + pc0 + oc0) - e, 32'd0);

        for (int i = 0; i < 4; i++) begin
            a = acc0; e = fc0 + pc0 + oc0;
            send3(tbl[i].w0, tbl[i].w1, tbl[i].w2);
            cyc(8);
            chk($sformatf("tbl%0d_count", i), acc0 - a, 32'd1);
            chk($sformatf("tbl%0d_data", i), {8'd0, last0}, {8'd0, tbl[i].exp});
            chk($sformatf("tbl%0d_errs", i), (fc0 + pc0 + oc0) - e, 32'd0);
        end

        // Framing error abandons the partial frame.
        a = acc0; f = fc0; p = pc0;
        send_word(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_word(1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("frm_err", fc0 - f, 32'd1);
        chk("frm_no_perr", pc0 - p, 32'd0);
        chk("frm_no_valid", acc0 - a, 32'd0);
        send3(8'h44, 8'h55, 8'h66);
        cyc(8);
        chk("frm_after_count", acc0 - a, 32'd1);
        chk("frm_after_data", {8'd0, last0}, 32'h665544);

        // Backpressure: second frame overruns, held data untouched.
        a = acc0; o = oc0;
        rdy0 = 1'b0;
        send3(8'h11, 8'h22, 8'h33);
        send3(8'h44, 8'h55, 8'h66);
        cyc(8);
        chk("bp_valid", {31'd0, v0}, 32'd1);
        chk("bp_data", {8'd0, d0}, 32'h332211);
        chk("bp_overrun", oc0 - o, 32'd1);
        rdy0 = 1'b1;
        cyc(1);
        chk("bp_drop", {31'd0, v0}, 32'd0);
        chk("bp_data_kept", {8'd0, d0}, 32'h332211);
        chk("bp_accepted", acc0 - a, 32'd1);

        // Reset in the middle of word 2 with a frame still held.
        rdy0 = 1'b0;
        send3(8'h11, 8'h22, 8'h33);
        send_word(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
        bitdrv(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bitdrv(1'b0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mrst_outs", {4'd0, d0, v0, fe0, pe0, oe0}, 32'd0);
        rx0 = 1'b1;
        cyc(3);
        rstn = 1'b1;
        rdy0 = 1'b1;
        cyc(10);
        a = acc0;
        send3(8'hAA, 8'hBB, 8'hCC);
        cyc(8);
        chk("mrst_count", acc0 - a, 32'd1);
        chk("mrst_data", {8'd0, last1 ^ last1 ^ last0}, 32'hCCBBAA);

        // Even parity instance.
        a = acc1; p = pc1; f = fc1;
        send_word(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("par_good", pc1 - p, 32'd0);
        send_word(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        cyc(2);
        chk("par_bad", pc1 - p, 32'd1);
        chk("par_no_valid", acc1 - a, 32'd0);
        send_even(8'h01);
        send_even(8'h02);
        send_even(8'h03);
        cyc(8);
        chk("par_count", acc1 - a, 32'd1);
        chk("par_data", {8'd0, last1}, 32'h030201);
        p = pc1;
        send_word(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        chk("prio_frame", fc1 - f, 32'd1);
        chk("prio_no_parity", pc1 - p, 32'd0);

        chk("no_multi_err", multi, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
